// File: rtl/slice_accum.sv
// Burst accumulator for the slice stage: sums x+y+bus_out+w2 per sample, folds BURST
// samples per entry and queues totals in a show-ahead FIFO. Optional macro: SLICE_ACCUM_SAT_EN.
module slice_accum #(
    parameter int DW    = 32,
    parameter int BUS_W = 16,
    parameter int W2_W  = 8,
    parameter int BURST = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BUS_W-1:0]             bus_out,
    input  logic [W2_W-1:0]              w2,
    input  logic [DW-1:0]                x,
    input  logic [DW-1:0]                y,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_sum,
    output logic [$clog2(BURST+1)-1:0]   out_cnt,
    output logic                         out_ovf,
    output logic                         busy
);

    localparam int CW  = $clog2(BURST + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ACC, DRAIN, PUSH} state_t;

    state_t          state, state_nxt;

    logic            accept;
    logic [DW+1:0]   s1_full;
    logic            s1_full_ovf;
    logic [DW-1:0]   s1_trunc;
    logic            s1_valid;
    logic [DW-1:0]   s1_sum;
    logic            s1_ovf;

    logic [DW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            sticky;
    logic [DW:0]     add_full;
    logic [DW-1:0]   add_sum;
    logic            add_flag;
    logic [CW-1:0]   cnt_inc;
    logic            burst_done;

    logic [DW-1:0]   mem_sum [DEPTH];
    logic [CW-1:0]   mem_cnt [DEPTH];
    logic            mem_ovf [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [FCW-1:0]  fifo_count;
    logic            push, pop, push_fl;
    logic [DW-1:0]   push_sum;
    logic [CW-1:0]   push_cnt;
    logic            push_ovf;

    // ---------------- stage 1: wide per-sample sum ----------------
    always_comb begin
        s1_full = (DW+2)'(x) + (DW+2)'(y) + (DW+2)'(bus_out) + (DW+2)'(w2);
        s1_full_ovf = |s1_full[DW+1:DW];
`ifdef SLICE_ACCUM_SAT_EN
        s1_trunc = s1_full_ovf ? '1 : s1_full[DW-1:0];
`else
        s1_trunc = s1_full[DW-1:0];
`endif
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ovf   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= s1_trunc;
                s1_ovf <= s1_full_ovf;
            end
        end
    end

    // ---------------- stage 2: burst accumulation ----------------
    always_comb begin
        add_full = {1'b0, acc} + {1'b0, s1_sum};
`ifdef SLICE_ACCUM_SAT_EN
        add_sum = add_full[DW] ? '1 : add_full[DW-1:0];
`else
        add_sum = add_full[DW-1:0];
`endif
        add_flag   = s1_ovf | add_full[DW] | sticky;
        cnt_inc    = cnt + CW'(1);
        burst_done = s1_valid && (cnt_inc == CW'(BURST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (s1_valid) begin
            if (burst_done) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else begin
                acc    <= add_sum;
                cnt    <= cnt_inc;
                sticky <= add_flag;
            end
        end else if (push_fl) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (flush) state_nxt = DRAIN;
            // s1 cannot refill here, so at most one cycle is spent waiting on it
            DRAIN:   if (!s1_valid) state_nxt = (cnt == '0) ? ACC : PUSH;
            PUSH:    if (push_fl) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_comb begin
        in_ready = !rst && (state == ACC) && !flush && (fifo_count <= FCW'(DEPTH - 2));
        push_fl  = (state == PUSH) && ((fifo_count < FCW'(DEPTH)) || pop);
        busy     = (state != ACC) || s1_valid || (cnt != '0);
    end

    // ---------------- output FIFO (show-ahead) ----------------
    // Stage-2 completions and partial-burst pushes never coincide: PUSH is entered only with s1 empty.
    always_comb begin
        push = burst_done | push_fl;
        pop  = out_valid & out_ready;
        if (burst_done) begin
            push_sum = add_sum;
            push_cnt = CW'(BURST);
            push_ovf = add_flag;
        end else begin
            push_sum = acc;
            push_cnt = cnt;
            push_ovf = sticky;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum[wr_ptr] <= push_sum;
            mem_cnt[wr_ptr] <= push_cnt;
            mem_ovf[wr_ptr] <= push_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        out_valid = (fifo_count != '0);
        out_sum   = out_valid ? mem_sum[rd_ptr] : '0;
        out_cnt   = out_valid ? mem_cnt[rd_ptr] : '0;
        out_ovf   = out_valid ? mem_ovf[rd_ptr] : 1'b0;
    end

endmodule
